// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM between the fetch and data-load ports, one-cycle registered response.
// Defining ROM_ARB_STARVE_GUARD_EN adds a bounded-wait guard that forces a fetch grant after MAX_WAIT denials.
module rom_arbiter #(
   parameter int ROM_WORDS = 4096,
   parameter int MAX_WAIT  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   output logic        if_err_o,
   input  logic        mem_req_i,
   input  logic [31:0] mem_addr_i,
   output logic        mem_gnt_o,
   output logic        mem_rvalid_o,
   output logic [31:0] mem_rdata_o,
   output logic        mem_err_o,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i
);

   localparam logic [31:0] ROM_WORDS_C = 32'(ROM_WORDS);

   if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
      $error("rom_arbiter: MAX_WAIT must be in 1..15");
   end

   function automatic logic addr_ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < ROM_WORDS_C);
   endfunction

   logic        guard_fire;
   logic        gnt_any;
   logic        gnt_legal;
   logic [31:0] gnt_addr;

   logic        if_rvalid_q, if_rvalid_d;
   logic        if_err_q, if_err_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic        mem_rvalid_q, mem_rvalid_d;
   logic        mem_err_q, mem_err_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;

`ifdef ROM_ARB_STARVE_GUARD_EN
   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [3:0] wait_q, wait_d;

   assign guard_fire = if_req_i && (wait_q == MAX_WAIT_C);

   // Counts consecutive denied fetch cycles; any fetch grant or idle fetch restarts the count.
   always_comb begin
      wait_d = wait_q;
      if (!if_req_i || if_gnt_o) begin
         wait_d = 4'd0;
      end else if (wait_q != MAX_WAIT_C) begin
         wait_d = wait_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_q <= 4'd0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   assign guard_fire = 1'b0;
`endif

   assign mem_gnt_o = mem_req_i && !guard_fire;
   assign if_gnt_o  = if_req_i && !mem_gnt_o;

   assign gnt_any   = if_gnt_o || mem_gnt_o;
   assign gnt_addr  = mem_gnt_o ? mem_addr_i : if_addr_i;
   assign gnt_legal = gnt_any && addr_ok(gnt_addr);

   // A bad address still consumes the slot but never reaches the ROM.
   assign rom_ce_o   = gnt_legal;
   assign rom_addr_o = gnt_legal ? gnt_addr : 32'd0;

   always_comb begin
      if_rvalid_d  = if_gnt_o;
      if_err_d     = if_gnt_o && !gnt_legal;
      if_rdata_d   = if_rdata_q;
      mem_rvalid_d = mem_gnt_o;
      mem_err_d    = mem_gnt_o && !gnt_legal;
      mem_rdata_d  = mem_rdata_q;
      if (if_gnt_o) begin
         if_rdata_d = gnt_legal ? rom_data_i : 32'd0;
      end
      if (mem_gnt_o) begin
         mem_rdata_d = gnt_legal ? rom_data_i : 32'd0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         if_rvalid_q  <= 1'b0;
         if_err_q     <= 1'b0;
         if_rdata_q   <= 32'd0;
         mem_rvalid_q <= 1'b0;
         mem_err_q    <= 1'b0;
         mem_rdata_q  <= 32'd0;
      end else begin
         if_rvalid_q  <= if_rvalid_d;
         if_err_q     <= if_err_d;
         if_rdata_q   <= if_rdata_d;
         mem_rvalid_q <= mem_rvalid_d;
         mem_err_q    <= mem_err_d;
         mem_rdata_q  <= mem_rdata_d;
      end
   end

   assign if_rvalid_o  = if_rvalid_q;
   assign if_err_o     = if_err_q;
   assign if_rdata_o   = if_rdata_q;
   assign mem_rvalid_o = mem_rvalid_q;
   assign mem_err_o    = mem_err_q;
   assign mem_rdata_o  = mem_rdata_q;

endmodule
